sdspi_cmdx: RTL and testbench
=============================

SDSPI_CMDX -- requirements
Module: sdspi_cmdx

Interface
REQ-001 SHALL have parameter NCR_MAX, default 8: maximum response bytes polled for the R1 start (bit7==0) before a response timeout.
REQ-002 SHALL have parameter LGBUSY, default 16: width of the R1b busy-byte counter; busy timeout occurs after 2^LGBUSY-1 busy (0x00) bytes.
REQ-003 SHALL have parameter OPT_CRC, default 1: 1 = compute CRC7; 0 = send the CRC byte as 8'hFF.
REQ-004 SHALL have ports, clock and reset first:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_cmd_stb  in  1  command request.
- i_cmd_type  in  2  response type: 0=R1, 1=R1b, 2=R2, 3=R3/R7.
- i_cmd  in  6  command index.
- i_cmd_data  in  32  argument.
- o_busy  out  1  command in progress.
- o_ll_stb  out  1  byte request to the SPI byte layer.
- o_ll_byte  out  8  byte to send.
- i_ll_busy  in  1  byte layer busy.
- i_ll_stb  in  1  received byte valid.
- i_ll_byte  in  8  received byte.
- o_cmd_sent  out  1  all 6 command bytes accepted.
- o_rxvalid  out  1  one-cycle completion pulse.
- o_response  out  40  {R1, trailing bytes}.
- o_err  out  2  bit0 response timeout, bit1 busy timeout.

Function
REQ-005 SHALL accept a command on i_cmd_stb && !o_busy; o_busy SHALL rise the next cycle; strobes while o_busy SHALL be ignored.
REQ-006 SHALL use states IDLE -> SEND -> WAIT_R1 -> {TAIL | BUSYWAIT | DONE} -> IDLE.
REQ-007 A byte SHALL be consumed on any cycle with o_ll_stb && !i_ll_busy; o_ll_byte SHALL hold stable while o_ll_stb && i_ll_busy.
REQ-008 SEND SHALL emit, in order: {2'b01, i_cmd}, arg[31:24], arg[23:16], arg[15:8], arg[7:0], {crc7, 1'b1}.
REQ-009 CRC7 SHALL use polynomial x^7+x^3+1, initial value 0, over the 40 command bits MSB first, 2 bits per cycle (20 cycles from acceptance).
REQ-010 SHALL hold o_ll_stb low before the CRC byte until the CRC computation completes.
REQ-011 o_cmd_sent SHALL rise the cycle after the CRC byte is consumed and stay high until IDLE.
REQ-012 After SEND, o_ll_stb SHALL stay high with o_ll_byte=8'hFF until completion.
REQ-013 Bytes on i_ll_stb before o_cmd_sent SHALL be ignored.
REQ-014 WAIT_R1: the first i_ll_stb byte with bit7==0 SHALL be stored in o_response[39:32].
REQ-015 WAIT_R1 timeout: NCR_MAX received bytes with bit7==1 SHALL complete with o_err=2'b01 and o_response=40'hFF_FFFF_FFFF.
REQ-016 After the R1 byte:
- R1: complete.
- R2: capture 1 byte into o_response[7:0].
- R3/R7: capture 4 bytes MSB first into o_response[31:0].
- R1b: enter BUSYWAIT.
REQ-017 Uncaptured response bytes SHALL read 8'hFF.
REQ-018 BUSYWAIT SHALL complete on the first received byte !=8'h00.
REQ-019 BUSYWAIT timeout: after 2^LGBUSY-1 consecutive 8'h00 bytes, SHALL complete with o_err=2'b10, R1 retained.
REQ-020 On completion o_rxvalid SHALL pulse exactly one cycle, o_busy and o_ll_stb SHALL fall in that same cycle, and o_response/o_err SHALL hold until the next accepted command.
REQ-021 On command acceptance, o_err SHALL clear to 0 and o_response SHALL be set to all-ones.
REQ-022 A received byte coincident with the completion cycle SHALL be ignored.
REQ-023 Counters SHALL saturate, never wrap.

Reset
REQ-024 i_reset SHALL, on the next edge, force IDLE regardless of state and set o_busy=0, o_ll_stb=0, o_cmd_sent=0, o_rxvalid=0, o_err=0, o_response=40'hFF_FFFF_FFFF, o_ll_byte=8'hFF, counters=0.

Verification
REQ-025 CMD0, arg 0, R1; byte layer replies FF, 01 -> sent bytes 40 00 00 00 00 95; o_response=40'h01_FFFF_FFFF; o_err=0; one o_rxvalid pulse.
REQ-026 CMD8, arg 32'h1AA, R7; replies 01 00 00 01 AA -> CRC byte 87; o_response=40'h01_0000_01AA.
REQ-027 R1, NCR_MAX=8, eight FF replies -> o_err=2'b01; o_response all-ones; o_busy drops.
REQ-028 CMD12 R1b; replies 00, 00, 00, FF -> o_response[39:32]=00; completion on the FF byte; o_err=0. With LGBUSY=2 and 3+ zero bytes -> o_err=2'b10.
REQ-029 i_ll_busy toggling randomly with 0-cycle gaps -> CRC byte withheld until the CRC is complete; byte order unchanged.
REQ-030 i_reset asserted mid-SEND (byte 3), then a new CMD0 -> clean IDLE outputs per REQ-024; new command bytes start at 40.

Source files
------------

// File: rtl/sdspi_cmdx.sv
//-----------------------------------------------------------------------------
// sdspi_cmdx
//
// Issues one SD-card SPI-mode command and collects its response. It sits above
// a byte-level SPI engine.
//
// A command is taken on i_cmd_stb while the block is idle. It is sent as a
// 6-byte frame: {01, index}, the four argument bytes MSB first, then
// {CRC7, 1}. The CRC7 is worked out two bits per cycle while the first five
// bytes go out. The CRC byte is held back until that work is done.
//
// After the frame has been sent, the block keeps asking the byte layer for
// 0xFF filler bytes and watches the bytes that come back:
//   * it polls up to NCR_MAX bytes for the R1 byte, which is the first byte
//     with bit 7 clear;
//   * R2 and R3/R7 then capture 1 or 4 trailing bytes;
//   * R1b then waits while the card returns 0x00 busy bytes.
// Completion is a one-cycle o_rxvalid pulse. o_response and o_err then hold
// until the next command is accepted.
//
// Parameters
//   NCR_MAX  bytes polled for the R1 start before a response timeout
//   LGBUSY   width of the busy counter; timeout after 2^LGBUSY-1 zero bytes
//   OPT_CRC  1: real CRC7 in the last byte, 0: last byte is 8'hFF
//
// Ports
//   i_clk, i_reset     clock; synchronous active-high reset
//   i_cmd_stb          command request (ignored while o_busy)
//   i_cmd_type         0=R1 1=R1b 2=R2 3=R3/R7
//   i_cmd, i_cmd_data  command index and 32-bit argument
//   o_busy             command in progress
//   o_ll_stb/o_ll_byte byte request to the SPI layer, taken when !i_ll_busy
//   i_ll_busy          byte layer cannot take a byte this cycle
//   i_ll_stb/i_ll_byte received byte from the SPI layer
//   o_cmd_sent         whole 6-byte frame has been accepted
//   o_rxvalid          one-cycle completion pulse
//   o_response         {R1, trailing bytes}; bytes not captured read 8'hFF
//   o_err              bit0 response timeout, bit1 busy timeout
//-----------------------------------------------------------------------------
module sdspi_cmdx #(
  parameter int NCR_MAX = 8,
  parameter int LGBUSY  = 16,
  parameter bit OPT_CRC = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_cmd_stb,
  input  logic [1:0]  i_cmd_type,
  input  logic [5:0]  i_cmd,
  input  logic [31:0] i_cmd_data,
  output logic        o_busy,
  output logic        o_ll_stb,
  output logic [7:0]  o_ll_byte,
  input  logic        i_ll_busy,
  input  logic        i_ll_stb,
  input  logic [7:0]  i_ll_byte,
  output logic        o_cmd_sent,
  output logic        o_rxvalid,
  output logic [39:0] o_response,
  output logic [1:0]  o_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_R1,
    S_TAIL,
    S_BUSYWAIT,
    S_DONE
  } state_t;

  localparam logic [1:0] RT_R1  = 2'd0;
  localparam logic [1:0] RT_R1B = 2'd1;
  localparam logic [1:0] RT_R2  = 2'd2;

  // The poll counter holds the number of 0xFF bytes already seen. When a byte
  // arrives with the count at NCR_LAST, that byte is the NCR_MAX-th one.
  localparam int                NCR_W    = (NCR_MAX < 2) ? 1 : $clog2(NCR_MAX);
  localparam logic [NCR_W-1:0]  NCR_LAST = NCR_W'(NCR_MAX - 1);

  // Same idea for the busy counter: a zero byte arriving at BUSY_LAST is
  // busy byte number 2^LGBUSY-1.
  localparam logic [LGBUSY-1:0] BUSY_ALL  = '1;
  localparam logic [LGBUSY-1:0] BUSY_LAST = BUSY_ALL - LGBUSY'(1);

  // 40 frame bits at 2 bits per cycle.
  localparam logic [4:0] CRC_STEPS = 5'd20;
  localparam logic [2:0] CRC_IDX   = 3'd5;

  // One serial step of CRC7, polynomial x^7 + x^3 + 1.
  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb        = b ^ c[6];
    crc7_step = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  // Frame byte k of the outgoing command. Byte 5 is the CRC byte.
  function automatic logic [7:0] frame_byte(input logic [39:0] f,
                                            input logic [6:0]  c,
                                            input logic [2:0]  k);
    case (k)
      3'd0:    frame_byte = f[39:32];
      3'd1:    frame_byte = f[31:24];
      3'd2:    frame_byte = f[23:16];
      3'd3:    frame_byte = f[15:8];
      3'd4:    frame_byte = f[7:0];
      default: frame_byte = OPT_CRC ? {c, 1'b1} : 8'hFF;
    endcase
  endfunction

  state_t              state_q,    state_d;
  logic                busy_q,     busy_d;
  logic                ll_stb_q,   ll_stb_d;
  logic [7:0]          ll_byte_q,  ll_byte_d;
  logic                cmd_sent_q, cmd_sent_d;
  logic                rxvalid_q,  rxvalid_d;
  logic [39:0]         response_q, response_d;
  logic [1:0]          err_q,      err_d;
  logic [1:0]          cmd_type_q, cmd_type_d;
  logic [39:0]         frame_q,    frame_d;
  logic [39:0]         crc_sr_q,   crc_sr_d;
  logic [6:0]          crc_q,      crc_d;
  logic [4:0]          crc_cnt_q,  crc_cnt_d;
  logic [2:0]          idx_q,      idx_d;
  logic [NCR_W-1:0]    ncr_cnt_q,  ncr_cnt_d;
  logic [1:0]          tail_cnt_q, tail_cnt_d;
  logic [LGBUSY-1:0]   busy_cnt_q, busy_cnt_d;

  logic       accept;
  logic       ll_take;
  logic       finish;
  logic       crc_ready;
  logic [1:0] tail_last;

  assign accept    = i_cmd_stb && !busy_q;
  assign ll_take   = ll_stb_q && !i_ll_busy;
  assign tail_last = (cmd_type_q == RT_R2) ? 2'd0 : 2'd3;

  always_comb begin
    // NOTE: every *_d starts as its *_q, so no path through this block leaves a
    // variable unassigned. An unassigned path would infer a latch.
    state_d    = state_q;
    busy_d     = busy_q;
    ll_stb_d   = ll_stb_q;
    ll_byte_d  = ll_byte_q;
    cmd_sent_d = cmd_sent_q;
    rxvalid_d  = 1'b0;
    response_d = response_q;
    err_d      = err_q;
    cmd_type_d = cmd_type_q;
    frame_d    = frame_q;
    crc_sr_d   = crc_sr_q;
    crc_d      = crc_q;
    crc_cnt_d  = crc_cnt_q;
    idx_d      = idx_q;
    ncr_cnt_d  = ncr_cnt_q;
    tail_cnt_d = tail_cnt_q;
    busy_cnt_d = busy_cnt_q;
    finish     = 1'b0;
    crc_ready  = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        // DONE lasts exactly one cycle (the o_rxvalid cycle). It behaves like
        // IDLE, so a new command can already be accepted in that cycle.
        state_d    = S_IDLE;
        cmd_sent_d = 1'b0;
        if (accept) begin
          state_d    = S_SEND;
          busy_d     = 1'b1;
          cmd_type_d = i_cmd_type;
          frame_d    = {2'b01, i_cmd, i_cmd_data};
          crc_sr_d   = {2'b01, i_cmd, i_cmd_data};
          crc_d      = 7'd0;
          crc_cnt_d  = 5'd0;
          idx_d      = 3'd0;
          ncr_cnt_d  = '0;
          tail_cnt_d = 2'd0;
          busy_cnt_d = '0;
          ll_stb_d   = 1'b1;
          ll_byte_d  = {2'b01, i_cmd};
          err_d      = 2'b00;
          response_d = '1;
        end
      end

      S_SEND: begin
        // CRC runs on its own schedule. It does not depend on when the byte
        // layer takes the bytes.
        if (crc_cnt_q != CRC_STEPS) begin
          crc_d     = crc7_step(crc7_step(crc_q, crc_sr_q[39]), crc_sr_q[38]);
          crc_sr_d  = {crc_sr_q[37:0], 2'b00};
          crc_cnt_d = crc_cnt_q + 5'd1;
        end
        crc_ready = !OPT_CRC || (crc_cnt_d == CRC_STEPS);

        if (ll_take) begin
          if (idx_q == CRC_IDX) begin
            state_d    = S_WAIT_R1;
            cmd_sent_d = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end

        if (state_d == S_SEND) begin
          // The CRC byte is only requested once its value is final. This also
          // keeps o_ll_byte stable while the layer stalls on it.
          ll_stb_d  = (idx_d != CRC_IDX) || crc_ready;
          ll_byte_d = frame_byte(frame_q, crc_d, idx_d);
        end else begin
          ll_stb_d  = 1'b1;
          ll_byte_d = 8'hFF;
        end
      end

      S_WAIT_R1: begin
        if (i_ll_stb) begin
          if (!i_ll_byte[7]) begin
            response_d[39:32] = i_ll_byte;
            case (cmd_type_q)
              RT_R1:   finish  = 1'b1;
              RT_R1B:  state_d = S_BUSYWAIT;
              default: state_d = S_TAIL;
            endcase
          end else if (ncr_cnt_q == NCR_LAST) begin
            err_d      = 2'b01;
            response_d = '1;
            finish     = 1'b1;
          end else begin
            ncr_cnt_d = ncr_cnt_q + NCR_W'(1);
          end
        end
      end

      S_TAIL: begin
        // Trailing bytes shift in from the bottom, starting from all-ones.
        // After one byte (R2) the upper bytes still read 0xFF. After four
        // bytes (R3/R7) the word sits MSB first in [31:0].
        if (i_ll_stb) begin
          response_d[31:0] = {response_q[23:0], i_ll_byte};
          if (tail_cnt_q == tail_last) begin
            finish = 1'b1;
          end else begin
            tail_cnt_d = tail_cnt_q + 2'd1;
          end
        end
      end

      S_BUSYWAIT: begin
        if (i_ll_stb) begin
          if (i_ll_byte != 8'h00) begin
            finish = 1'b1;
          end else if (busy_cnt_q == BUSY_LAST) begin
            err_d  = 2'b10;
            finish = 1'b1;
          end else begin
            busy_cnt_d = busy_cnt_q + LGBUSY'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (finish) begin
      state_d   = S_DONE;
      busy_d    = 1'b0;
      ll_stb_d  = 1'b0;
      ll_byte_d = 8'hFF;
      rxvalid_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments, so every flop samples the *_d values
    // from before this edge. The result does not depend on statement order.
    if (i_reset) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      ll_stb_q   <= 1'b0;
      ll_byte_q  <= 8'hFF;
      cmd_sent_q <= 1'b0;
      rxvalid_q  <= 1'b0;
      response_q <= '1;
      err_q      <= 2'b00;
      cmd_type_q <= 2'd0;
      frame_q    <= '0;
      crc_sr_q   <= '0;
      crc_q      <= 7'd0;
      crc_cnt_q  <= 5'd0;
      idx_q      <= 3'd0;
      ncr_cnt_q  <= '0;
      tail_cnt_q <= 2'd0;
      busy_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      ll_stb_q   <= ll_stb_d;
      ll_byte_q  <= ll_byte_d;
      cmd_sent_q <= cmd_sent_d;
      rxvalid_q  <= rxvalid_d;
      response_q <= response_d;
      err_q      <= err_d;
      cmd_type_q <= cmd_type_d;
      frame_q    <= frame_d;
      crc_sr_q   <= crc_sr_d;
      crc_q      <= crc_d;
      crc_cnt_q  <= crc_cnt_d;
      idx_q      <= idx_d;
      ncr_cnt_q  <= ncr_cnt_d;
      tail_cnt_q <= tail_cnt_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign o_busy     = busy_q;
  assign o_ll_stb   = ll_stb_q;
  assign o_ll_byte  = ll_byte_q;
  assign o_cmd_sent = cmd_sent_q;
  assign o_rxvalid  = rxvalid_q;
  assign o_response = response_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_sdspi_cmdx.sv
//-----------------------------------------------------------------------------
// tb_sdspi_cmdx
//
// Bench for sdspi_cmdx. It uses NCR_MAX=8 and LGBUSY=2, so the busy timeout is
// reached after three zero bytes.
//
// The bench acts as the SPI byte layer. Outgoing bytes are recorded when the
// layer takes them. Reply bytes come from a queue. The expected frame, CRC,
// response, error code and reply-byte count come from a reference model that
// works on the whole reply list at once.
//-----------------------------------------------------------------------------
module tb_sdspi_cmdx;

  localparam int NCR_MAX    = 8;
  localparam int LGBUSY     = 2;
  localparam int BUSY_LIMIT = (1 << LGBUSY) - 1;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_cmd_stb;
  logic [1:0]  i_cmd_type;
  logic [5:0]  i_cmd;
  logic [31:0] i_cmd_data;
  logic        o_busy;
  logic        o_ll_stb;
  logic [7:0]  o_ll_byte;
  logic        i_ll_busy;
  logic        i_ll_stb;
  logic [7:0]  i_ll_byte;
  logic        o_cmd_sent;
  logic        o_rxvalid;
  logic [39:0] o_response;
  logic [1:0]  o_err;

  always #5 clk = ~clk;

  sdspi_cmdx #(.NCR_MAX(NCR_MAX), .LGBUSY(LGBUSY), .OPT_CRC(1'b1)) dut (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_cmd_stb  (i_cmd_stb),
    .i_cmd_type (i_cmd_type),
    .i_cmd      (i_cmd),
    .i_cmd_data (i_cmd_data),
    .o_busy     (o_busy),
    .o_ll_stb   (o_ll_stb),
    .o_ll_byte  (o_ll_byte),
    .i_ll_busy  (i_ll_busy),
    .i_ll_stb   (i_ll_stb),
    .i_ll_byte  (i_ll_byte),
    .o_cmd_sent (o_cmd_sent),
    .o_rxvalid  (o_rxvalid),
    .o_response (o_response),
    .o_err      (o_err)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  rep_q[$];
  logic [39:0] last_resp;
  logic [1:0]  last_err;
  logic [7:0]  last_crc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // CRC7 (x^7+x^3+1, init 0) over the 40 frame bits, one bit at a time.
  function automatic logic [7:0] model_crc_byte(input logic [39:0] bits);
    logic [6:0] c;
    logic       fb;
    c = 7'd0;
    for (int i = 39; i >= 0; i--) begin
      fb = bits[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return {c, 1'b1};
  endfunction

  // Expected response and error for the reply list in rep_q. 'used' is the
  // number of reply bytes the block should read up to and including the byte
  // that completes the command.
  function automatic void model_resp(input logic [1:0] typ, output logic [39:0] resp,
                                     output logic [1:0] err, output int used);
    int k;
    int zeros;
    resp = '1;
    err  = 2'b00;
    k    = 0;
    while (k < NCR_MAX && k < rep_q.size() && rep_q[k][7]) k++;
    if (k >= NCR_MAX) begin
      err  = 2'b01;
      used = NCR_MAX;
      return;
    end
    resp[39:32] = rep_q[k];
    used        = k + 1;
    case (typ)
      2'd2: begin
        resp[7:0] = rep_q[used];
        used      = used + 1;
      end
      2'd3: begin
        for (int j = 0; j < 4; j++) resp[31 - 8*j -: 8] = rep_q[used + j];
        used = used + 4;
      end
      2'd1: begin
        zeros = 0;
        while (zeros < BUSY_LIMIT && used < rep_q.size() && rep_q[used] == 8'h00) begin
          zeros++;
          used++;
        end
        if (zeros == BUSY_LIMIT) err = 2'b10;
        else                     used = used + 1;
      end
      default: ;
    endcase
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"},     o_busy,     0);
    check({tag, "_ll_stb"},   o_ll_stb,   0);
    check({tag, "_ll_byte"},  o_ll_byte,  8'hFF);
    check({tag, "_cmd_sent"}, o_cmd_sent, 0);
    check({tag, "_rxvalid"},  o_rxvalid,  0);
    check({tag, "_err"},      o_err,      0);
    check({tag, "_response"}, o_response, 40'hFF_FFFF_FFFF);
  endtask

  // Runs one command against the reply list in rep_q.
  task automatic run_cmd(input logic [5:0] cmd, input logic [31:0] arg, input logic [1:0] typ,
                         input int busy_pct, input int gap_pct);
    logic [47:0] exp_frame;
    logic [39:0] exp_resp;
    logic [1:0]  exp_err;
    int          exp_used;
    logic [7:0]  sent_q[$];
    int          cyc;
    int          rp;
    bit          done;
    bit          hold;
    bit          crc_seen;
    bit          b;
    logic [7:0]  hold_byte;

    exp_frame = {2'b01, cmd, arg, model_crc_byte({2'b01, cmd, arg})};
    model_resp(typ, exp_resp, exp_err, exp_used);

    @(negedge clk);
    i_cmd_stb  = 1'b1;
    i_cmd      = cmd;
    i_cmd_data = arg;
    i_cmd_type = typ;
    i_ll_stb   = 1'b0;
    i_ll_busy  = 1'b0;
    @(negedge clk);
    i_cmd_stb = 1'b0;
    check("accept_busy",     o_busy,     1);
    check("accept_err",      o_err,      0);
    check("accept_response", o_response, 40'hFF_FFFF_FFFF);

    cyc = 0; rp = 0; done = 0; hold = 0; crc_seen = 0; hold_byte = 8'h00;
    while (!done && cyc < 4000) begin
      if (o_rxvalid) begin
        check("done_busy",     o_busy,     0);
        check("done_ll_stb",   o_ll_stb,   0);
        check("done_response", o_response, exp_resp);
        check("done_err",      o_err,      exp_err);
        check("done_bytes_used", rp,       exp_used);
        last_resp = o_response;
        last_err  = o_err;
        // A received byte in the completion cycle must be ignored.
        i_cmd_stb = 1'b0;
        i_ll_busy = 1'b0;
        i_ll_stb  = 1'b1;
        i_ll_byte = 8'h00;
        @(negedge clk);
        i_ll_stb = 1'b0;
        check("rxvalid_one_cycle", o_rxvalid,  0);
        check("hold_response",     o_response, exp_resp);
        check("hold_err",          o_err,      exp_err);
        check("idle_busy",         o_busy,     0);
        done = 1;
      end else begin
        check("in_progress_busy", o_busy, 1);
        check("cmd_sent", o_cmd_sent, sent_q.size() == 6);
        if (hold) begin
          check("stall_ll_stb",  o_ll_stb,  1);
          check("stall_ll_byte", o_ll_byte, hold_byte);
        end
        if (o_cmd_sent) begin
          check("fill_ll_stb",  o_ll_stb,  1);
          check("fill_ll_byte", o_ll_byte, 8'hFF);
        end else if (o_ll_stb && sent_q.size() == 5 && !crc_seen) begin
          crc_seen = 1;
          check("crc_byte_withheld", cyc >= 20, 1);
        end

        b         = ($urandom_range(99) < busy_pct);
        i_ll_busy = b;
        if (o_ll_stb && !b && !o_cmd_sent) sent_q.push_back(o_ll_byte);
        hold      = o_ll_stb && b;
        hold_byte = o_ll_byte;

        if (o_cmd_sent) begin
          if (rp < rep_q.size() && $urandom_range(99) >= gap_pct) begin
            i_ll_stb  = 1'b1;
            i_ll_byte = rep_q[rp];
            rp++;
          end else begin
            i_ll_stb  = 1'b0;
            i_ll_byte = 8'($urandom);
          end
        end else begin
          // Bytes arriving before the frame is sent must not count as R1.
          i_ll_stb  = ($urandom_range(3) == 0);
          i_ll_byte = 8'h00;
        end

        // Strobes while busy must not start a new command.
        i_cmd_stb  = o_busy && ($urandom_range(5) == 0);
        i_cmd      = ~cmd;
        i_cmd_data = ~arg;
        i_cmd_type = ~typ;

        @(negedge clk);
        cyc++;
      end
    end
    i_cmd_stb = 1'b0;
    i_ll_stb  = 1'b0;
    i_ll_busy = 1'b0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL completion: no o_rxvalid within %0d cycles", cyc);
    end
    check("sent_count", sent_q.size(), 6);
    for (int k = 0; k < 6 && k < sent_q.size(); k++)
      check($sformatf("sent_byte%0d", k), sent_q[k], exp_frame[47 - 8*k -: 8]);
    last_crc = (sent_q.size() > 5) ? sent_q[5] : 8'h00;
  endtask

  typedef struct {
    logic [5:0]  cmd;
    logic [31:0] arg;
    logic [1:0]  typ;
    logic [63:0] rep;
    int          nrep;
    logic [39:0] exp_resp;
    logic [1:0]  exp_err;
    logic [7:0]  exp_crc;   // 0 = not pinned down by this vector
  } vec_t;

  localparam int NV = 9;
  vec_t vecs[NV];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;

    i_reset = 1'b1; i_cmd_stb = 1'b0; i_cmd_type = 2'd0; i_cmd = 6'd0;
    i_cmd_data = 32'd0; i_ll_busy = 1'b0; i_ll_stb = 1'b0; i_ll_byte = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_state("por");
    i_reset = 1'b0;

    vecs[0] = '{cmd:6'd0,  arg:32'h0,     typ:2'd0, rep:64'hFF01,             nrep:2,
                exp_resp:40'h01_FFFF_FFFF, exp_err:2'b00, exp_crc:8'h95};
    vecs[1] = '{cmd:6'd8,  arg:32'h1AA,   typ:2'd3, rep:64'h01_0000_01AA,     nrep:5,
                exp_resp:40'h01_0000_01AA, exp_err:2'b00, exp_crc:8'h87};
    vecs[2] = '{cmd:6'd0,  arg:32'h0,     typ:2'd0, rep:64'hFFFF_FFFF_FFFF_FFFF, nrep:8,
                exp_resp:40'hFF_FFFF_FFFF, exp_err:2'b01, exp_crc:8'h95};
    vecs[3] = '{cmd:6'd12, arg:32'h0,     typ:2'd1, rep:64'h0000_00FF,        nrep:4,
                exp_resp:40'h00_FFFF_FFFF, exp_err:2'b00, exp_crc:8'h00};
    vecs[4] = '{cmd:6'd12, arg:32'h0,     typ:2'd1, rep:64'h0000_0000,        nrep:4,
                exp_resp:40'h00_FFFF_FFFF, exp_err:2'b10, exp_crc:8'h00};
    vecs[5] = '{cmd:6'd9,  arg:32'h0,     typ:2'd2, rep:64'hFF_053C,          nrep:3,
                exp_resp:40'h05_FFFF_FF3C, exp_err:2'b00, exp_crc:8'h00};
    vecs[6] = '{cmd:6'd55, arg:32'h0,     typ:2'd0, rep:64'hFFFF_FFFF_FFFF_FF00, nrep:8,
                exp_resp:40'h00_FFFF_FFFF, exp_err:2'b00, exp_crc:8'h00};
    vecs[7] = '{cmd:6'd38, arg:32'h1234,  typ:2'd1, rep:64'h0400_0007,        nrep:4,
                exp_resp:40'h04_FFFF_FFFF, exp_err:2'b00, exp_crc:8'h00};
    vecs[8] = '{cmd:6'd58, arg:32'h0,     typ:2'd3, rep:64'hFF01_C0FF_8000,   nrep:6,
                exp_resp:40'h01_C0FF_8000, exp_err:2'b00, exp_crc:8'h00};

    for (int v = 0; v < NV; v++) begin
      rep_q.delete();
      for (int j = 0; j < vecs[v].nrep; j++)
        rep_q.push_back(vecs[v].rep[8*(vecs[v].nrep - 1 - j) +: 8]);
      run_cmd(vecs[v].cmd, vecs[v].arg, vecs[v].typ, 0, 0);
      check($sformatf("vec%0d_response", v), last_resp, vecs[v].exp_resp);
      check($sformatf("vec%0d_err", v), last_err, vecs[v].exp_err);
      if (vecs[v].exp_crc != 8'h00)
        check($sformatf("vec%0d_crc", v), last_crc, vecs[v].exp_crc);
    end

    // CMD8 again, with the byte layer stalling about half the time.
    rep_q.delete();
    rep_q = '{8'h01, 8'h00, 8'h00, 8'h01, 8'hAA};
    run_cmd(6'd8, 32'h1AA, 2'd3, 50, 20);
    check("stalled_cmd8_crc", last_crc, 8'h87);
    check("stalled_cmd8_response", last_resp, 40'h01_0000_01AA);

    // Reset while byte 3 of the frame is on offer, then a clean CMD0.
    @(negedge clk);
    i_cmd_stb = 1'b1; i_cmd = 6'd17; i_cmd_data = 32'hA1B2_C3D4; i_cmd_type = 2'd0;
    i_ll_busy = 1'b0; i_ll_stb = 1'b0;
    @(negedge clk);
    i_cmd_stb = 1'b0;
    n = 0;
    while (o_ll_byte !== 8'hC3 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("midsend_byte3", o_ll_byte, 8'hC3);
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    check_reset_state("midsend_rst");
    @(negedge clk);
    check("midsend_still_idle", o_ll_stb, 0);
    rep_q.delete();
    rep_q = '{8'hFF, 8'h01};
    run_cmd(6'd0, 32'h0, 2'd0, 0, 0);
    check("post_reset_crc", last_crc, 8'h95);

    // Random commands and replies, checked against the model.
    for (int t = 0; t < 40; t++) begin
      logic [1:0] typ;
      bool_all_ff: begin
        rep_q.delete();
        if ($urandom_range(7) == 0) begin
          for (int j = 0; j < 16; j++) rep_q.push_back(8'hFF);
        end else begin
          for (int j = 0; j < 16; j++) begin
            if ($urandom_range(2) == 0)      rep_q.push_back(8'hFF);
            else if ($urandom_range(1) == 0) rep_q.push_back(8'h00);
            else                             rep_q.push_back(8'($urandom));
          end
        end
      end
      typ = 2'($urandom_range(3));
      run_cmd(6'($urandom), $urandom, typ, 40, 30);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
